// File: rtl/scb_master.sv
// scb_master: SCB bus initiator for the 1024x16 scratchpad responder.
// Takes one core-side load/store at a time and steers it onto the 16-bit
// byte-strobed SCB bus. It waits on scb_rdy_i, absorbs the one-cycle SRAM
// read latency, and returns the result on a valid/ready response channel.
//
// Optional build macro: SCB_MASTER_TIMEOUT_EN
//   When defined, an access that sees scb_rdy_i low for TIMEOUT cycles is
//   abandoned and answered with rsp_err_o=1.
//   When undefined, there is no counter, no TIMEOUT parameter, and ACCESS
//   waits indefinitely.
module scb_master #(
    parameter int A = 11,
    parameter int D = 16
`ifdef SCB_MASTER_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 15
`endif
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           req_valid_i,
    output logic           req_ready_o,
    input  logic [A-1:0]   req_addr_i,
    input  logic [D-1:0]   req_wdata_i,
    input  logic           req_we_i,
    input  logic           req_size_i,
    input  logic           req_signed_i,
    output logic           rsp_valid_o,
    input  logic           rsp_ready_i,
    output logic [D-1:0]   rsp_rdata_o,
    output logic           rsp_err_o,
    output logic [A-1:0]   scb_Addr_o,
    output logic [D-1:0]   scb_Data_o,
    input  logic [D-1:0]   scb_Data_i,
    output logic [1:0]     scb_stb_o,
    output logic           scb_ce_o,
    output logic           scb_rd_o,
    output logic           scb_wr_o,
    input  logic           scb_rdy_i
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RDATA,
        RESP
    } state_t;

    state_t state;

    // Only the parts of the request that are still needed after the bus
    // cycle has been launched are kept: direction, size, sign and byte lane.
    logic we_q;
    logic size_q;
    logic signed_q;
    logic odd_q;

    logic [D-1:0] load_data;
    logic [7:0]   lane_byte;

`ifdef SCB_MASTER_TIMEOUT_EN
    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    logic [CW-1:0] wait_cnt;
`endif

    // Shape the returned read data from the responder bus: a full word, or
    // the addressed lane zero- or sign-extended.
    always_comb begin
        lane_byte = odd_q ? scb_Data_i[15:8] : scb_Data_i[7:0];
        load_data = '0;
        if (size_q) begin
            load_data = scb_Data_i;
        end else if (signed_q) begin
            load_data = {{(D-8){lane_byte[7]}}, lane_byte};
        end else begin
            load_data = {{(D-8){1'b0}}, lane_byte};
        end
    end

    // Transaction FSM. Every output is a register and is loaded together
    // with the state it belongs to, so the bus never glitches.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state       <= IDLE;
            we_q        <= 1'b0;
            size_q      <= 1'b0;
            signed_q    <= 1'b0;
            odd_q       <= 1'b0;
            req_ready_o <= 1'b1;
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
            scb_Addr_o  <= '0;
            scb_Data_o  <= '0;
            scb_stb_o   <= 2'b00;
            scb_ce_o    <= 1'b0;
            scb_rd_o    <= 1'b0;
            scb_wr_o    <= 1'b1;
`ifdef SCB_MASTER_TIMEOUT_EN
            wait_cnt    <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid_i) begin
                        we_q        <= req_we_i;
                        size_q      <= req_size_i;
                        signed_q    <= req_signed_i;
                        odd_q       <= req_addr_i[0];
                        req_ready_o <= 1'b0;
                        if (req_size_i && req_addr_i[0]) begin
                            // A misaligned word access is answered at once;
                            // it never reaches the bus.
                            state       <= RESP;
                            rsp_valid_o <= 1'b1;
                            rsp_err_o   <= 1'b1;
                            rsp_rdata_o <= '0;
                        end else begin
                            state      <= ACCESS;
                            scb_ce_o   <= 1'b1;
                            scb_Addr_o <= req_addr_i;
                            if (req_size_i) begin
                                scb_stb_o <= 2'b11;
                            end else if (req_addr_i[0]) begin
                                scb_stb_o <= 2'b10;
                            end else begin
                                scb_stb_o <= 2'b01;
                            end
                            if (req_we_i) begin
                                scb_wr_o <= 1'b0;
                                scb_rd_o <= 1'b0;
                                if (req_size_i) begin
                                    scb_Data_o <= req_wdata_i;
                                end else begin
                                    scb_Data_o <= {req_wdata_i[7:0], req_wdata_i[7:0]};
                                end
                            end else begin
                                scb_wr_o   <= 1'b1;
                                scb_rd_o   <= 1'b1;
                                scb_Data_o <= '0;
                            end
`ifdef SCB_MASTER_TIMEOUT_EN
                            wait_cnt <= '0;
`endif
                        end
                    end
                end

                ACCESS: begin
                    if (scb_rdy_i) begin
                        scb_ce_o   <= 1'b0;
                        scb_rd_o   <= 1'b0;
                        scb_wr_o   <= 1'b1;
                        scb_stb_o  <= 2'b00;
                        scb_Data_o <= '0;
                        if (we_q) begin
                            state       <= RESP;
                            rsp_valid_o <= 1'b1;
                            rsp_err_o   <= 1'b0;
                            rsp_rdata_o <= '0;
                            scb_Addr_o  <= '0;
                        end else begin
                            // The address stays on the bus through RDATA
                            // because the responder picks its output bank
                            // from it.
                            state <= RDATA;
                        end
                    end
`ifdef SCB_MASTER_TIMEOUT_EN
                    else if (wait_cnt == CW'(TIMEOUT - 1)) begin
                        // This is the TIMEOUT-th stalled cycle, so the
                        // access is abandoned.
                        state       <= RESP;
                        scb_ce_o    <= 1'b0;
                        scb_rd_o    <= 1'b0;
                        scb_wr_o    <= 1'b1;
                        scb_stb_o   <= 2'b00;
                        scb_Data_o  <= '0;
                        scb_Addr_o  <= '0;
                        rsp_valid_o <= 1'b1;
                        rsp_err_o   <= 1'b1;
                        rsp_rdata_o <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end

                RDATA: begin
                    state       <= RESP;
                    scb_Addr_o  <= '0;
                    rsp_valid_o <= 1'b1;
                    rsp_err_o   <= 1'b0;
                    rsp_rdata_o <= load_data;
                end

                RESP: begin
                    if (rsp_ready_i) begin
                        state       <= IDLE;
                        rsp_valid_o <= 1'b0;
                        rsp_rdata_o <= '0;
                        rsp_err_o   <= 1'b0;
                        req_ready_o <= 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scb_master.sv
// tb_scb_master: self-checking bench for scb_master.
// A behavioural SRAM responder sits on the SCB side. Expected responses come
// from a flat byte-array model of the scratchpad, updated per request.
module tb_scb_master;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [10:0] req_addr_i;
    logic [15:0] req_wdata_i;
    logic        req_we_i;
    logic        req_size_i;
    logic        req_signed_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [15:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic [10:0] scb_Addr_o;
    logic [15:0] scb_Data_o;
    logic [15:0] scb_Data_i;
    logic [1:0]  scb_stb_o;
    logic        scb_ce_o;
    logic        scb_rd_o;
    logic        scb_wr_o;
    logic        scb_rdy_i = 1'b1;

    int pass_count  = 0;
    int fail_count  = 0;
    int check_count = 0;

    // Responder state and the byte-level reference model
    logic [15:0] sram [1024];
    logic [15:0] sram_q = 16'h0000;
    logic [7:0]  ref_mem [2048];

    // Bus monitor counters
    int          stall_left = 0;
    bit          rand_rdy   = 1'b0;
    int          ce_cycles  = 0;
    int          wr_cycles  = 0;
    int          addr_bad   = 0;
    int          proto_bad  = 0;
    bit          prev_ce    = 1'b0;
    logic [10:0] prev_addr  = '0;

    // Bus values seen in the first cycle after accept
    logic [10:0] acc_addr;
    logic [15:0] acc_data;
    logic [1:0]  acc_stb;
    logic        acc_ce;
    logic        acc_wr;
    logic        acc_rd;

    logic [15:0] rd;
    logic        er;
    int          ed;

    scb_master dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .req_addr_i   (req_addr_i),
        .req_wdata_i  (req_wdata_i),
        .req_we_i     (req_we_i),
        .req_size_i   (req_size_i),
        .req_signed_i (req_signed_i),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_ready_i  (rsp_ready_i),
        .rsp_rdata_o  (rsp_rdata_o),
        .rsp_err_o    (rsp_err_o),
        .scb_Addr_o   (scb_Addr_o),
        .scb_Data_o   (scb_Data_o),
        .scb_Data_i   (scb_Data_i),
        .scb_stb_o    (scb_stb_o),
        .scb_ce_o     (scb_ce_o),
        .scb_rd_o     (scb_rd_o),
        .scb_wr_o     (scb_wr_o),
        .scb_rdy_i    (scb_rdy_i)
    );

    always #5 clk_i = ~clk_i;

    assign scb_Data_i = sram_q;

    // Synchronous SRAM responder: byte-lane writes, read data one cycle later
    always @(posedge clk_i) begin
        if (scb_ce_o && scb_rdy_i) begin
            if (!scb_wr_o) begin
                if (scb_stb_o[0]) sram[scb_Addr_o[10:1]][7:0]  <= scb_Data_o[7:0];
                if (scb_stb_o[1]) sram[scb_Addr_o[10:1]][15:8] <= scb_Data_o[15:8];
            end else if (scb_rd_o) begin
                sram_q <= sram[scb_Addr_o[10:1]];
            end
        end
    end

    // Ready driver: forced stalls first, then random or always-ready
    always @(negedge clk_i) begin
        if (stall_left > 0 && scb_ce_o) begin
            scb_rdy_i = 1'b0;
            stall_left--;
        end else if (rand_rdy) begin
            scb_rdy_i = ($urandom_range(0, 3) != 0);
        end else begin
            scb_rdy_i = 1'b1;
        end
    end

    // Bus monitor sampled mid-cycle
    always @(negedge clk_i) begin
        if (scb_ce_o) begin
            ce_cycles++;
            if (!scb_wr_o) wr_cycles++;
            if (prev_ce && scb_Addr_o !== prev_addr) addr_bad++;
        end
        if (!scb_ce_o && !scb_wr_o) proto_bad++;
        prev_ce   = scb_ce_o;
        prev_addr = scb_Addr_o;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        check_count++;
        assert (observed === expected) pass_count++;
        else begin
            fail_count++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Scratchpad semantics at request level
    task automatic refAccess(input logic we, input logic size, input logic sgn,
                             input logic [10:0] addr, input logic [15:0] wdata,
                             output logic [15:0] exp_rdata, output logic exp_err);
        logic [7:0] b;
        exp_rdata = 16'h0000;
        exp_err   = 1'b0;
        if (size && addr[0]) begin
            exp_err = 1'b1;
        end else if (we) begin
            ref_mem[addr] = wdata[7:0];
            if (size) ref_mem[addr + 11'd1] = wdata[15:8];
        end else if (size) begin
            exp_rdata = {ref_mem[addr + 11'd1], ref_mem[addr]};
        end else begin
            b = ref_mem[addr];
            exp_rdata = sgn ? {{8{b[7]}}, b} : {8'h00, b};
        end
    endtask

    // Issue one request, check the response against the model (or against a
    // timeout error), optionally holding rsp_ready_i low for 'hold' cycles.
    task automatic applyStimulus(input logic we, input logic size, input logic sgn,
                                 input logic [10:0] addr, input logic [15:0] wdata,
                                 input int hold, input bit exp_timeout,
                                 output logic [15:0] rdata, output logic err,
                                 output int edges);
        logic [15:0] exp_rdata;
        logic        exp_err;
        int          waited;
        if (exp_timeout) begin
            exp_rdata = 16'h0000;
            exp_err   = 1'b1;
        end else begin
            refAccess(we, size, sgn, addr, wdata, exp_rdata, exp_err);
        end
        rsp_ready_i = (hold == 0);
        @(negedge clk_i);
        waited = 0;
        while (!req_ready_o && waited < 50) begin
            @(negedge clk_i);
            waited++;
        end
        if (!req_ready_o) begin
            check_count++;
            fail_count++;
            $error("[TB] FAIL req_ready_wait: observed 0 expected 1 within 50 cycles");
        end
        req_we_i     = we;
        req_size_i   = size;
        req_signed_i = sgn;
        req_addr_i   = addr;
        req_wdata_i  = wdata;
        req_valid_i  = 1'b1;
        @(posedge clk_i);
        #1;
        req_valid_i = 1'b0;
        acc_addr  = scb_Addr_o;
        acc_data  = scb_Data_o;
        acc_stb   = scb_stb_o;
        acc_ce    = scb_ce_o;
        acc_wr    = scb_wr_o;
        acc_rd    = scb_rd_o;
        ce_cycles = 0;
        wr_cycles = 0;
        addr_bad  = 0;
        edges     = 1;
        while (!rsp_valid_o && edges < 400) begin
            @(posedge clk_i);
            #1;
            edges++;
        end
        if (!rsp_valid_o) begin
            check_count++;
            fail_count++;
            $error("[TB] FAIL rsp_wait: observed no rsp_valid_o expected one within 400 edges");
        end
        rdata = rsp_rdata_o;
        err   = rsp_err_o;
        checkOutput("rsp_rdata", rsp_rdata_o, exp_rdata);
        checkOutput("rsp_err", rsp_err_o, exp_err);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk_i);
            #1;
            checkOutput("hold_valid", rsp_valid_o, 1);
            checkOutput("hold_rdata", rsp_rdata_o, exp_rdata);
            checkOutput("hold_err", rsp_err_o, exp_err);
            checkOutput("hold_req_ready", req_ready_o, 0);
        end
        rsp_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        checkOutput("rsp_done", rsp_valid_o, 0);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_req_ready"}, req_ready_o, 1);
        checkOutput({tag, "_rsp_valid"}, rsp_valid_o, 0);
        checkOutput({tag, "_rsp_rdata"}, rsp_rdata_o, 0);
        checkOutput({tag, "_rsp_err"}, rsp_err_o, 0);
        checkOutput({tag, "_bus_addr_data_stb"}, {scb_Addr_o, scb_Data_o, scb_stb_o}, 0);
        checkOutput({tag, "_ce_rd_wr"}, {scb_ce_o, scb_rd_o, scb_wr_o}, 3'b001);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) sram[i] = 16'h0000;
        for (int i = 0; i < 2048; i++) ref_mem[i] = 8'h00;
        rst_i        = 1'b0;
        req_valid_i  = 1'b0;
        req_addr_i   = '0;
        req_wdata_i  = '0;
        req_we_i     = 1'b0;
        req_size_i   = 1'b0;
        req_signed_i = 1'b0;
        rsp_ready_i  = 1'b1;

        // Step 1: reset state
        repeat (3) @(posedge clk_i);
        #1;
        checkResetValues("reset");
        @(negedge clk_i);
        rst_i = 1'b1;

        // Step 2: word store then word load at 0x004
        applyStimulus(1, 1, 0, 11'h004, 16'hBEEF, 0, 0, rd, er, ed);
        checkOutput("wst_stb", acc_stb, 2'b11);
        checkOutput("wst_ce_wr_rd", {acc_ce, acc_wr, acc_rd}, 3'b100);
        checkOutput("wst_addr", acc_addr, 11'h004);
        checkOutput("wst_data", acc_data, 16'hBEEF);
        checkOutput("wst_wr_cycles", wr_cycles, 1);
        checkOutput("wst_latency", ed, 2);
        applyStimulus(0, 1, 0, 11'h004, 16'h0000, 0, 0, rd, er, ed);
        checkOutput("wld_data", rd, 16'hBEEF);
        checkOutput("wld_ce_wr_rd", {acc_ce, acc_wr, acc_rd}, 3'b111);
        checkOutput("wld_latency", ed, 3);

        // Step 3: byte store to odd lane, signed/unsigned/word readback
        applyStimulus(1, 0, 0, 11'h401, 16'h12A5, 0, 0, rd, er, ed);
        checkOutput("bst_stb", acc_stb, 2'b10);
        checkOutput("bst_data", acc_data, 16'hA5A5);
        applyStimulus(0, 0, 1, 11'h401, 16'h0000, 0, 0, rd, er, ed);
        checkOutput("bld_signed", rd, 16'hFFA5);
        checkOutput("bld_stb", acc_stb, 2'b10);
        applyStimulus(0, 0, 0, 11'h401, 16'h0000, 0, 0, rd, er, ed);
        checkOutput("bld_unsigned", rd, 16'h00A5);
        applyStimulus(0, 1, 0, 11'h400, 16'h0000, 0, 0, rd, er, ed);
        checkOutput("wld_upper_byte", rd[15:8], 8'hA5);

        // Step 4: misaligned word load
        applyStimulus(0, 1, 0, 11'h003, 16'h0000, 0, 0, rd, er, ed);
        checkOutput("mis_err", er, 1);
        checkOutput("mis_rdata", rd, 0);
        checkOutput("mis_latency", ed, 1);
        checkOutput("mis_ce_cycles", ce_cycles, 0);

        // Step 5: five stall cycles on a load, then hold the response
        applyStimulus(1, 1, 0, 11'h010, 16'h1234, 0, 0, rd, er, ed);
        stall_left = 5;
        applyStimulus(0, 1, 0, 11'h010, 16'h0000, 3, 0, rd, er, ed);
        checkOutput("stall_data", rd, 16'h1234);
        checkOutput("stall_ce_cycles", ce_cycles, 6);
        checkOutput("stall_addr_stable", addr_bad, 0);
        checkOutput("stall_latency", ed, 8);

        // Step 6: asynchronous reset during RDATA
        @(negedge clk_i);
        req_we_i     = 1'b0;
        req_size_i   = 1'b1;
        req_signed_i = 1'b0;
        req_addr_i   = 11'h004;
        req_valid_i  = 1'b1;
        @(posedge clk_i);
        #1;
        req_valid_i = 1'b0;
        @(posedge clk_i);
        #1;
        checkOutput("rdata_ce_rd_wr", {scb_ce_o, scb_rd_o, scb_wr_o}, 3'b001);
        checkOutput("rdata_addr_held", scb_Addr_o, 11'h004);
        #2;
        rst_i = 1'b0;
        #1;
        checkResetValues("midreset");
        repeat (2) begin
            @(posedge clk_i);
            #1;
            checkOutput("midreset_no_rsp", rsp_valid_o, 0);
        end
        @(negedge clk_i);
        rst_i = 1'b1;
        applyStimulus(0, 1, 0, 11'h004, 16'h0000, 0, 0, rd, er, ed);
        checkOutput("after_reset_load", rd, 16'hBEEF);

        // Step 7: responder stuck not-ready
`ifdef SCB_MASTER_TIMEOUT_EN
        stall_left = 1000;
        applyStimulus(0, 1, 0, 11'h004, 16'h0000, 0, 1, rd, er, ed);
        stall_left = 0;
        checkOutput("timeout_err", er, 1);
        checkOutput("timeout_ce_cycles", ce_cycles, 15);
        checkOutput("timeout_latency", ed, 16);
        checkOutput("timeout_ce_dropped", scb_ce_o, 0);
`else
        stall_left = 100;
        applyStimulus(0, 1, 0, 11'h004, 16'h0000, 0, 0, rd, er, ed);
        checkOutput("long_stall_ce_cycles", ce_cycles, 101);
        checkOutput("long_stall_latency", ed, 103);
        checkOutput("long_stall_data", rd, 16'hBEEF);
`endif

        // Step 8: random traffic with random responder readiness
        rand_rdy = 1'b1;
        for (int n = 0; n < 60; n++) begin
            logic [10:0] a;
            a = 11'($urandom_range(0, 15));
            if ($urandom_range(0, 1) != 0) a[10] = 1'b1;
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), a, 16'($urandom()),
                          $urandom_range(0, 2), 0, rd, er, ed);
        end
        rand_rdy = 1'b0;

        checkOutput("wr_low_outside_access", proto_bad, 0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/scb_master.md
Name: scb_master

Overview:
- SCB bus initiator. Converts single core-side load/store requests into SCB transactions toward the 1024x16 scratchpad responder, which has 11-bit byte addresses, 16-bit data and a 2-bit byte strobe.
- Handles byte-lane steering, waits on scb_rdy_i, and hides the one-cycle synchronous SRAM read latency.
- Returns each result on a valid/ready response channel.
- One request is outstanding at a time.

Parameters:
A, 11, SCB byte address width
D, 16, SCB data width (fixed 16; byte lanes [7:0] even, [15:8] odd)
TIMEOUT, 15, max ACCESS cycles with scb_rdy_i low (used only with SCB_MASTER_TIMEOUT_EN)

Ports:
clk_i  in  1  clock, all state updates on rising edge
rst_i  in  1  asynchronous, active-low reset
req_valid_i  in  1  request valid
req_ready_o  out  1  request accepted when valid&ready
req_addr_i  in  A  byte address
req_wdata_i  in  16  store data; byte store uses [7:0]
req_we_i  in  1  1=store, 0=load
req_size_i  in  1  0=byte, 1=word
req_signed_i  in  1  byte load sign-extends when 1
rsp_valid_o  out  1  response valid
rsp_ready_i  in  1  response consumed when valid&ready
rsp_rdata_o  out  16  load data (0 for stores/errors)
rsp_err_o  out  1  misaligned or timed-out access
scb_Addr_o  out  A  SCB address
scb_Data_o  out  16  SCB write data
scb_Data_i  in  16  SCB read data
scb_stb_o  out  2  byte strobes, [1]=odd lane, [0]=even lane
scb_ce_o  out  1  chip enable
scb_rd_o  out  1  high during read access cycle
scb_wr_o  out  1  active-low write strobe; 0 with ce=1 writes
scb_rdy_i  in  1  responder ready

Behaviour:
- Reset (rst_i=0, asynchronous): state=IDLE. Outputs: req_ready_o=1, rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0, scb_Addr_o=0, scb_Data_o=0, scb_stb_o=0, scb_ce_o=0, scb_rd_o=0, scb_wr_o=1.
- A reset mid-transaction aborts it with no response, and the bus returns to idle immediately.
- States: IDLE, ACCESS, RDATA, RESP. All SCB outputs are registered.
- IDLE:
  - req_ready_o=1.
  - On accept: register addr, data and controls.
  - Word access at an odd address -> RESP with rsp_err_o=1, rsp_rdata_o=0, and no bus cycle.
  - Otherwise -> ACCESS.
- ACCESS:
  - scb_ce_o=1 and scb_Addr_o=addr.
  - Strobes: word=2'b11; byte even=2'b01; byte odd=2'b10.
  - Store: scb_wr_o=0, scb_rd_o=0. Word drives wdata; byte drives {wdata[7:0],wdata[7:0]}.
  - Load: scb_wr_o=1, scb_rd_o=1.
  - Stays in ACCESS while scb_rdy_i=0.
  - On scb_rdy_i=1: store -> RESP; load -> RDATA.
- RDATA:
  - scb_ce_o=0, scb_rd_o=0, scb_wr_o=1; scb_Addr_o is held, because the responder selects its output bank from the address.
  - Capture scb_Data_i at the end of this cycle.
  - Word load -> rdata=data. Byte load -> selected lane, zero-extended, or sign-extended if req_signed_i.
  - Next state: RESP.
- RESP:
  - rsp_valid_o=1; rdata and err are stable until rsp_ready_i=1, then -> IDLE.
  - req_ready_o=0 in every state except IDLE.
- Latency with rsp_ready_i=1 and scb_rdy_i=1: store response 2 edges after accept; load 3 edges; misaligned 1 edge.
- Back-to-back throughput: one request per (latency+1) cycles.
- scb_ce_o must never be asserted outside ACCESS. scb_wr_o=0 only in ACCESS for stores.
- Address is used as-is: no wrap and no range check beyond A bits.

Optional Feature:
- Macro SCB_MASTER_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to ACCESS and increments each ACCESS cycle with scb_rdy_i=0.
  - When the count reaches TIMEOUT: deassert scb_ce_o and go to RESP with rsp_err_o=1, rsp_rdata_o=0.
  - scb_rdy_i=1 in the same cycle as the count reaching TIMEOUT wins, and the access completes normally.
- Undefined: no counter; ACCESS waits on scb_rdy_i indefinitely.

Test Plan:
- Word store addr 0x004, data 0xBEEF, then word load 0x004 -> stb=11 and wr=0 for one cycle; load returns 0xBEEF, err=0, 3 edges after accept.
- Byte store 0x0A5 at 0x401 (odd, high bank) -> stb=10, scb_Data_o=0xA5A5; signed byte load 0x401 -> 0xFFA5; unsigned -> 0x00A5; word load 0x400 shows upper byte 0xA5.
- Word load at 0x003 -> rsp_err_o=1, rdata=0, scb_ce_o never asserted.
- scb_rdy_i held low 5 cycles during a load -> ce stays high 6 cycles with address stable, then a correct read; hold rsp_ready_i low 3 cycles -> rsp fields stable, req_ready_o=0.
- rst_i pulsed low during RDATA -> all outputs at reset values asynchronously, no response; next request completes normally.
- With SCB_MASTER_TIMEOUT_EN and TIMEOUT=15, scb_rdy_i stuck low -> err=1 after 15 ACCESS cycles and ce drops; without the macro, still in ACCESS after 100 cycles.
